vend_ctrl: RTL and testbench
============================

# vend_ctrl

Vending sequencer built on top of the coin-credit accumulator. It collects 1/5/10-unit coin pulses into a saturating-checked credit register, and accepts a purchase when credit covers the selected item price. After a purchase it issues a one-cycle vend strobe, then drives the change dispenser one coin at a time over a req/ack handshake until the remaining credit is zero. A cancel refunds all credit through the same change path.

## Interface
- PRICE0, default 3: price of item 0, legal range 1..31
- PRICE1, default 6: price of item 1, legal range 1..31
- PRICE2, default 8: price of item 2, legal range 1..31
- PRICE3, default 12: price of item 3, legal range 1..31
- clk  in  1  clock; reset reset, asynchronous, active-high
- reset  in  1  asynchronous, active-high
- coin1, coin5, coin10  in  1 each  single-cycle coin-accepted pulses, synchronous to clk
- sel  in  2  item select; sampled only in the cycle buy is high
- buy  in  1  purchase request pulse
- cancel  in  1  refund request pulse
- chg_ack  in  1  change dispenser has taken the currently requested coin
- credit  out  5  current credit in units
- vend  out  1  one-cycle item release strobe
- chg5_req  out  1  request one 5-unit coin from the dispenser
- chg1_req  out  1  request one 1-unit coin from the dispenser
- coin_rej  out  1  one-cycle pulse: a coin was not credited and must be returned mechanically
- busy  out  1  high whenever state is not COLLECT

## Operation
- States: COLLECT, VEND, CHANGE. Reset state is COLLECT. All outputs are decoded from registers only; there is no combinational input-to-output path.
- Reset values: credit=0, vend=0, chg5_req=0, chg1_req=0, coin_rej=0, busy=0. Reset asserted mid-operation aborts immediately. Any in-flight change is lost and the dispenser sees its request drop.
- COLLECT, in priority order each cycle:
  - cancel: if credit>0, go to CHANGE; if credit==0, stay in COLLECT with no effect. cancel beats buy.
  - buy with credit >= PRICE[sel]: credit <= credit - PRICE[sel], go to VEND.
  - buy with credit < PRICE[sel]: ignored. Coins in that cycle are processed normally.
  - Coins: when several coin inputs are high in one cycle, only the highest value is considered (coin10 > coin5 > coin1). All others are rejected.
  - A considered coin is added if credit + value <= 31; otherwise it is rejected and credit is unchanged.
  - Coins arriving in a cycle where cancel or buy is accepted are rejected.
- VEND: lasts exactly one cycle, vend=1. Next state is CHANGE if credit>0, else COLLECT.
- CHANGE:
  - chg5_req = (credit>=5); chg1_req = (0<credit<5). At most one request is high at a time.
  - On chg_ack with a request high, credit decreases by 5 or 1. When the new credit is 0, go to COLLECT.
  - chg_ack with no request high is ignored.
  - buy and cancel are ignored. All coins are rejected.
- coin_rej: registered, high in cycle n+1 if any coin pulse in cycle n was not credited. It is a single bit regardless of how many coins were rejected.

## Timing
- Coin pulse in cycle n: credit updated and visible at n+1.
- Accepted buy in cycle n: vend=1 and reduced credit at n+1. The first change request, if any, appears at n+2.
- Accepted cancel in cycle n: first change request at n+1.
- Each change request is held until acked. Ack in cycle m: credit updated at m+1, and the next request (or return to COLLECT) is visible at m+1.
- Back-to-back acks are legal, giving one coin per cycle.
- Worst-case refund of 31 is 6×5 + 1×1, i.e. 7 handshakes.

## Test plan
- Reset; coin5, coin5, coin1 on consecutive cycles -> credit 5, 10, 11. Then sel=2, buy -> vend pulse and credit 3 next cycle; chg1_req ×3 with ack each -> credit 0, busy=0.
- Credit 30; coin5 -> coin_rej pulse, credit stays 30. Then coin1 -> credit 31, no coin_rej.
- Credit 7; sel=3, buy -> no vend, credit 7. Then cancel -> chg5_req (ack) -> credit 2; chg1_req ×2 (ack) -> credit 0, state COLLECT.
- Credit 12; buy (sel=0) and cancel in the same cycle -> no vend. Refund sequence is 5, 5, 1, 1 and final credit is 0.
- coin10 and coin1 in the same cycle from credit 0 -> credit 10 and one coin_rej pulse. A coin pulse during CHANGE -> coin_rej, credit unaffected. chg_ack pulses in COLLECT -> no effect.
- Reset asserted in CHANGE while chg5_req is high (credit 9) -> credit 0, all requests low immediately. After release, coin1 -> credit 1.

Source files
------------

// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-credit vending sequencer with purchase, vend strobe and
// one-coin-at-a-time change/refund handshake.
module vend_ctrl #(
    parameter int PRICE0 = 3,
    parameter int PRICE1 = 6,
    parameter int PRICE2 = 8,
    parameter int PRICE3 = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin1_i,
    input  logic       coin5_i,
    input  logic       coin10_i,
    input  logic [1:0] sel_i,
    input  logic       buy_i,
    input  logic       cancel_i,
    input  logic       chg_ack_i,
    output logic [4:0] credit_o,
    output logic       vend_o,
    output logic       chg5_req_o,
    output logic       chg1_req_o,
    output logic       coin_rej_o,
    output logic       busy_o
);
    typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

    state_t     state_q, state_d;
    logic [4:0] credit_q, credit_d;
    logic       coin_rej_q, coin_rej_d;
    logic [4:0] price, coin_val, chg_val;
    logic [5:0] coin_sum;
    logic       any_coin, multi, fits, cancel_ok, buy_ok;

    assign price     = sel_i == 2'd0 ? 5'(PRICE0) :
                       sel_i == 2'd1 ? 5'(PRICE1) :
                       sel_i == 2'd2 ? 5'(PRICE2) : 5'(PRICE3);
    assign coin_val  = coin10_i ? 5'd10 : coin5_i ? 5'd5 : coin1_i ? 5'd1 : 5'd0;
    assign any_coin  = coin1_i | coin5_i | coin10_i;
    assign multi     = (coin10_i & (coin5_i | coin1_i)) | (coin5_i & coin1_i);
    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_val};
    assign fits      = coin_sum <= 6'd31;
    assign cancel_ok = cancel_i && credit_q != 5'd0;
    assign buy_ok    = buy_i && credit_q >= price;
    assign chg_val   = credit_q >= 5'd5 ? 5'd5 : 5'd1;

    // Any coin not explicitly credited below is flagged for mechanical return.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        coin_rej_d = any_coin;
        case (state_q)
            COLLECT: begin
                if (cancel_ok) begin
                    state_d = CHANGE;
                end else if (buy_ok) begin
                    credit_d = credit_q - price;
                    state_d  = VEND;
                end else begin
                    if (any_coin && fits) credit_d = coin_sum[4:0];
                    coin_rej_d = any_coin && (multi || !fits);
                end
            end
            VEND:    state_d = credit_q != 5'd0 ? CHANGE : COLLECT;
            CHANGE: begin
                if (credit_q == 5'd0) begin
                    state_d = COLLECT;
                end else if (chg_ack_i) begin
                    credit_d = credit_q - chg_val;
                    state_d  = credit_d == 5'd0 ? COLLECT : CHANGE;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= COLLECT;
            credit_q   <= 5'd0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign credit_o   = credit_q;
    assign vend_o     = state_q == VEND;
    assign chg5_req_o = state_q == CHANGE && credit_q >= 5'd5;
    assign chg1_req_o = state_q == CHANGE && credit_q != 5'd0 && credit_q < 5'd5;
    assign coin_rej_o = coin_rej_q;
    assign busy_o     = state_q != COLLECT;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed self-checking bench for vend_ctrl.
module tb_vend_ctrl;
    logic       clk = 1'b0, reset = 1'b1;
    logic       coin1 = 0, coin5 = 0, coin10 = 0, buy = 0, cancel = 0, ack = 0;
    logic [1:0] sel = 0;
    logic [4:0] credit;
    logic       vend, chg5, chg1, coin_rej, busy;
    int         checks = 0, failures = 0, seq;

    vend_ctrl dut (
        .clk(clk), .reset(reset), .coin1_i(coin1), .coin5_i(coin5), .coin10_i(coin10),
        .sel_i(sel), .buy_i(buy), .cancel_i(cancel), .chg_ack_i(ack),
        .credit_o(credit), .vend_o(vend), .chg5_req_o(chg5), .chg1_req_o(chg1),
        .coin_rej_o(coin_rej), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input int v);
        coin1 = v == 1; coin5 = v == 5; coin10 = v == 10;
        step();
        coin1 = 0; coin5 = 0; coin10 = 0;
    endtask

    // Hold ack high and record each request as a decimal digit (5 or 1).
    task automatic drain();
        seq = 0;
        ack = 1;
        for (int i = 0; i < 16 && busy; i++) begin
            seq = seq * 10 + (chg5 ? 5 : chg1 ? 1 : 0);
            step();
        end
        ack = 0;
    endtask

    initial begin
        step(); step();
        chk("rst_credit", credit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_reqs", {vend, chg5, chg1, coin_rej}, 0);
        reset = 0;
        step();

        coin(5);  chk("t1_c5a", credit, 5);
        coin(5);  chk("t1_c5b", credit, 10);
        coin(1);  chk("t1_c1", credit, 11);
        sel = 2; buy = 1; step(); buy = 0;
        chk("t1_vend", vend, 1);
        chk("t1_credit_after_buy", credit, 3);
        step();
        chk("t1_vend_off", vend, 0);
        chk("t1_chg1", {chg5, chg1}, 1);
        drain();
        chk("t1_seq", seq, 111);
        chk("t1_credit0", credit, 0);
        chk("t1_idle", busy, 0);

        coin(10); coin(10); coin(10);
        chk("t2_credit30", credit, 30);
        coin(5);
        chk("t2_rej", coin_rej, 1);
        chk("t2_credit_keep", credit, 30);
        coin(1);
        chk("t2_credit31", credit, 31);
        chk("t2_no_rej", coin_rej, 0);
        cancel = 1; step(); cancel = 0;
        chk("t2_first_req", {chg5, chg1}, 2);
        drain();
        chk("t2_seq31", seq, 5555551);
        chk("t2_credit0", credit, 0);

        coin(5); coin(1); coin(1);
        chk("t3_credit7", credit, 7);
        sel = 3; buy = 1; step(); buy = 0;
        chk("t3_no_vend", vend, 0);
        chk("t3_credit_keep", credit, 7);
        chk("t3_idle", busy, 0);
        cancel = 1; step(); cancel = 0;
        step();
        chk("t3_hold_req", {chg5, chg1}, 2);
        chk("t3_hold_credit", credit, 7);
        drain();
        chk("t3_seq", seq, 511);
        chk("t3_done", {busy, credit}, 0);

        coin(10); coin(1); coin(1);
        chk("t4_credit12", credit, 12);
        sel = 0; buy = 1; cancel = 1; step(); buy = 0; cancel = 0;
        chk("t4_no_vend", vend, 0);
        chk("t4_credit_keep", credit, 12);
        drain();
        chk("t4_seq", seq, 5511);
        chk("t4_credit0", credit, 0);

        coin10 = 1; coin1 = 1; step(); coin10 = 0; coin1 = 0;
        chk("t5_multi_credit", credit, 10);
        chk("t5_multi_rej", coin_rej, 1);
        step();
        chk("t5_rej_pulse", coin_rej, 0);
        cancel = 1; step(); cancel = 0;
        coin(1);
        chk("t5_change_rej", coin_rej, 1);
        chk("t5_change_credit", credit, 10);
        drain();
        chk("t5_seq", seq, 55);
        coin(1);
        ack = 1; step(); ack = 0;
        chk("t5_ack_collect", credit, 1);
        chk("t5_ack_idle", busy, 0);
        sel = 1; buy = 1; coin5 = 1; step(); buy = 0; coin5 = 0;
        chk("t5_poor_buy_coin", credit, 6);
        chk("t5_poor_buy_vend", {vend, coin_rej}, 0);
        sel = 1; buy = 1; coin1 = 1; step(); buy = 0; coin1 = 0;
        chk("t5_exact_vend", vend, 1);
        chk("t5_exact_credit", credit, 0);
        chk("t5_buy_coin_rej", coin_rej, 1);
        step();
        chk("t5_back_collect", busy, 0);

        coin(5); coin(1); coin(1); coin(1); coin(1);
        chk("t6_credit9", credit, 9);
        cancel = 1; step(); cancel = 0;
        chk("t6_req5", chg5, 1);
        #2 reset = 1;
        #1;
        chk("t6_async_credit", credit, 0);
        chk("t6_async_reqs", {chg5, chg1, busy}, 0);
        step();
        reset = 0;
        coin(1);
        chk("t6_after_reset", credit, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
